// File: rtl/bram_access_scheduler_pkg.sv
// Shared definitions for cache-RAM access controllers.
package bram_access_scheduler_pkg;

  // state         | meaning
  // ST_CLEAR      | zero-filling the RAM after reset, requests held off
  // ST_RUN        | clear finished, write arbitration and reads active
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } sched_state_t;

  localparam int STARVE_LIMIT_DEF = 3;
  localparam int STARVE_W         = 4;

endpackage

// File: rtl/bram_wr_arbiter.sv
// Two-way fixed-priority write arbiter; an aging counter forces a grant to
// the low-priority requester after it has lost starve_limit cycles in a row.
module bram_wr_arbiter
  import bram_access_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          valid,
  input  logic [STARVE_W-1:0] starve_limit,
  output logic [1:0]          grant
);

  logic [STARVE_W-1:0] starve_cnt;

  // Grant from current requests and age only; never depends on a ready.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid[1] && (!valid[0] || starve_cnt == starve_limit)) grant = 2'b10;
      else if (valid[0])                                          grant = 2'b01;
    end
  end

  // Count consecutive lost cycles of requester 1, saturating at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           starve_cnt <= '0;
    else if (!valid[1] || grant[1])     starve_cnt <= '0;
    else if (en && starve_cnt < starve_limit) starve_cnt <= starve_cnt + 1'b1;
  end

endmodule

// File: rtl/bram_access_scheduler.sv
// Front end for one true-dual-port BRAM: zero-fill after reset, arbitrate
// two writers onto port A, serve reads on port B with same-cycle forwarding.
module bram_access_scheduler
  import bram_access_scheduler_pkg::*;
#(
  parameter  int DATA_WIDTH   = 32,
  parameter  int DEPTH        = 128,
  parameter  int STARVE_LIMIT = STARVE_LIMIT_DEF,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w0_valid,
  output logic                  w0_ready,
  input  logic [AW-1:0]         w0_addr,
  input  logic [DATA_WIDTH-1:0] w0_data,
  input  logic                  w1_valid,
  output logic                  w1_ready,
  input  logic [AW-1:0]         w1_addr,
  input  logic [DATA_WIDTH-1:0] w1_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [AW-1:0]         rd_addr,
  output logic                  rd_rvalid,
  output logic [DATA_WIDTH-1:0] rd_rdata,
  output logic                  init_done,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [AW-1:0]         ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  ram_enb,
  output logic [AW-1:0]         ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_doutb
);

  sched_state_t          state, state_nxt;
  logic [AW-1:0]         clr_cnt;
  logic [1:0]            grant;
  logic                  wr_hit;
  logic                  hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign init_done = (state == ST_RUN);
  assign w0_ready  = grant[0];
  assign w1_ready  = grant[1];
  assign rd_ready  = init_done;
  assign ram_enb   = rd_valid & rd_ready;
  assign ram_addrb = rd_addr;

  bram_wr_arbiter u_arb (
    .clk          (clk),
    .rst          (rst),
    .en           (init_done),
    .valid        ({w1_valid, w0_valid}),
    .starve_limit (STARVE_W'(STARVE_LIMIT)),
    .grant        (grant)
  );

  // State register and clear address counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Leave CLEAR once the last entry is written; only reset returns to CLEAR.
  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && clr_cnt == AW'(DEPTH - 1)) state_nxt = ST_RUN;
  end

  // Port A mux; reset is folded in so the RAM sees no write while held.
  always_comb begin
    ram_ena   = 1'b0;
    ram_wea   = 1'b0;
    ram_addra = '0;
    ram_dina  = '0;
    if (rst) begin
      if (state == ST_CLEAR) begin
        ram_ena   = 1'b1;
        ram_wea   = 1'b1;
        ram_addra = clr_cnt;
      end else if (grant[0]) begin
        ram_ena   = 1'b1;
        ram_wea   = 1'b1;
        ram_addra = w0_addr;
        ram_dina  = w0_data;
      end else if (grant[1]) begin
        ram_ena   = 1'b1;
        ram_wea   = 1'b1;
        ram_addra = w1_addr;
        ram_dina  = w1_data;
      end
    end
  end

  // Port B returns undefined data on a same-address same-cycle write.
  assign wr_hit = ram_enb & ram_ena & ram_wea & (ram_addra == rd_addr);

  // Read pipeline: valid, forward flag/data, and the held last result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_rvalid <= 1'b0;
      hit       <= 1'b0;
      fwd_data  <= '0;
      rdata_q   <= '0;
    end else begin
      rd_rvalid <= ram_enb;
      hit       <= wr_hit;
      if (wr_hit)    fwd_data <= ram_dina;
      if (rd_rvalid) rdata_q  <= rd_rdata;
    end
  end

  assign rd_rdata = rd_rvalid ? (hit ? fwd_data : ram_doutb) : rdata_q;

endmodule

// File: tb/tb_bram_access_scheduler.sv
// Bench for bram_access_scheduler with a BRAM model and a reference model.
module tb_bram_access_scheduler;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int LIMIT = 3;

  logic          clk, rst;
  logic          w0_valid, w0_ready, w1_valid, w1_ready;
  logic [AW-1:0] w0_addr, w1_addr, rd_addr;
  logic [DW-1:0] w0_data, w1_data;
  logic          rd_valid, rd_ready, rd_rvalid, init_done;
  logic [DW-1:0] rd_rdata;
  logic          ram_ena, ram_wea, ram_enb;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina, ram_doutb;

  int checks = 0;
  int errors = 0;

  bram_access_scheduler #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .w0_valid(w0_valid), .w0_ready(w0_ready), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_valid(w1_valid), .w1_ready(w1_ready), .w1_addr(w1_addr), .w1_data(w1_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata), .init_done(init_done),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // BRAM model: port B data is garbage on a same-address write collision.
  logic [DW-1:0] bram [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) bram[i] = 32'hA5A50000 + DW'(i);
    ram_doutb = 32'h0;
  end
  always @(posedge clk) begin
    if (ram_enb)
      ram_doutb <= (ram_ena && ram_wea && ram_addra == ram_addrb) ? 32'hBADC0DE5 : bram[ram_addrb];
    if (ram_ena && ram_wea) bram[ram_addra] <= ram_dina;
  end

  // Reference model: memory contents, clear progress, w1 loss count, read result.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            m_clearing = 1'b1;
  int            m_clr_pos  = 0;
  int            m_lost     = 0;
  bit            m_rv       = 1'b0;
  logic [DW-1:0] m_rdata    = '0;
  logic [DW-1:0] m_last     = '0;
  int            w1_wait    = 0;
  int            w1_wait_max = 0;
  bit            eg0, eg1;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_wdata;

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_rvalid", rd_rvalid, 0);
      check("rst_rdata", rd_rdata, 0);
      check("rst_readies", {w0_ready, w1_ready, rd_ready}, 0);
      check("rst_ram_en", {ram_ena, ram_wea, ram_enb}, 0);
      check("rst_init_done", init_done, 0);
      m_clearing = 1'b1; m_clr_pos = 0; m_lost = 0; m_rv = 1'b0; m_last = '0; w1_wait = 0;
    end else begin
      check("rvalid", rd_rvalid, m_rv);
      check("rdata", rd_rdata, m_rv ? m_rdata : m_last);
      if (m_rv) m_last = m_rdata;
      if (m_clearing) begin
        check("clr_port_a", {ram_ena, ram_wea}, 2'b11);
        check("clr_addra", ram_addra, m_clr_pos);
        check("clr_dina", ram_dina, 0);
        check("clr_readies", {w0_ready, w1_ready, rd_ready, init_done, ram_enb}, 0);
        ref_mem[m_clr_pos] = '0;
        if (m_clr_pos == DEPTH - 1) m_clearing = 1'b0;
        m_clr_pos++;
        m_rv = 1'b0;
      end else begin
        eg1 = w1_valid && (!w0_valid || m_lost == LIMIT);
        eg0 = w0_valid && !eg1;
        e_waddr = eg1 ? w1_addr : w0_addr;
        e_wdata = eg1 ? w1_data : w0_data;
        check("grants", {w1_ready, w0_ready}, {eg1, eg0});
        check("port_a_en", {ram_ena, ram_wea}, {eg0 | eg1, eg0 | eg1});
        if (eg0 | eg1) begin
          check("addra", ram_addra, e_waddr);
          check("dina", ram_dina, e_wdata);
        end
        check("run_ready", {rd_ready, init_done}, 2'b11);
        check("enb", ram_enb, rd_valid);
        if (rd_valid) check("addrb", ram_addrb, rd_addr);
        m_rv = rd_valid;
        if (rd_valid)
          m_rdata = ((eg0 | eg1) && e_waddr == rd_addr) ? e_wdata : ref_mem[rd_addr];
        if (eg0 | eg1) ref_mem[e_waddr] = e_wdata;
        if (w1_valid && !eg1) m_lost = (m_lost < LIMIT) ? m_lost + 1 : LIMIT;
        else                  m_lost = 0;
        if (w1_valid && !w1_ready) w1_wait++;
        else                       w1_wait = 0;
        if (w1_wait > w1_wait_max) w1_wait_max = w1_wait;
      end
    end
  end

  task automatic idle();
    w0_valid = 0; w1_valid = 0; rd_valid = 0;
  endtask

  task automatic wait_init();
    for (int i = 0; i < 2 * DEPTH + 4 && !init_done; i++) @(negedge clk);
    check("init_timeout", init_done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int       clr_seen, ready_seen;
  bit [7:0] g0_seq, g1_seq;

  initial begin
    rst = 0; idle();
    w0_addr = '0; w1_addr = '0; rd_addr = '0; w0_data = '0; w1_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    // T1: clear sweep with requests pending
    w0_valid = 1; w0_addr = 3'd1; w0_data = 32'h11; rd_valid = 1; rd_addr = 3'd2;
    clr_seen = 0; ready_seen = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (ram_ena && ram_wea && ram_addra == AW'(i) && ram_dina == 0) clr_seen++;
      if (w0_ready || w1_ready || rd_ready || init_done) ready_seen++;
    end
    check("t1_clear_writes", clr_seen, 8);
    check("t1_ready_during_clear", ready_seen, 0);
    @(negedge clk);
    check("t1_init_done_cycle9", init_done, 1);
    check("t1_w0_first_grant", w0_ready, 1);

    // T2: constant contention, w1 forced every fourth cycle
    @(posedge clk); #1;
    w0_valid = 1; w0_addr = 3'd5; w0_data = 32'h5555_0005;
    w1_valid = 1; w1_addr = 3'd6; w1_data = 32'h6666_0006;
    rd_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      g0_seq[i] = w0_ready;
      g1_seq[i] = w1_ready;
    end
    check("t2_w1_grant_pattern", g1_seq, 8'h88);
    check("t2_w0_grant_pattern", g0_seq, 8'h77);

    // T3: same-cycle write/read collision is forwarded
    @(posedge clk); #1;
    idle();
    w0_valid = 1; w0_addr = 3'd3; w0_data = 32'hDEADBEEF;
    rd_valid = 1; rd_addr = 3'd3;
    @(posedge clk); #1 idle();
    @(negedge clk);
    check("t3_fwd_rvalid", rd_rvalid, 1);
    check("t3_fwd_rdata", rd_rdata, 32'hDEADBEEF);

    // T4: write then read next cycle comes straight from the RAM
    @(posedge clk); #1;
    w0_valid = 1; w0_addr = 3'd7; w0_data = 32'h12345678;
    @(posedge clk); #1;
    w0_valid = 0; rd_valid = 1; rd_addr = 3'd7;
    @(posedge clk); #1 idle();
    @(negedge clk);
    check("t4_raw_rvalid", rd_rvalid, 1);
    check("t4_raw_rdata", rd_rdata, 32'h12345678);

    // T5a: reset during clear at entry 4
    @(posedge clk); #1 rst = 0;
    #1 check("t5_async_init_done", init_done, 0);
    @(posedge clk); #1 rst = 1;
    repeat (4) @(posedge clk);
    #1 check("t5_clear_at_4", ram_addra, 4);
    rst = 0;
    #1 check("t5_async_port_a", {ram_ena, ram_wea}, 0);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    check("t5_clear_restart_addr", ram_addra, 0);
    check("t5_clear_restart_we", ram_wea, 1);
    wait_init();

    // T5b: reset during streaming reads
    @(posedge clk); #1 rd_valid = 1; rd_addr = 3'd0;
    @(posedge clk); #1 rd_addr = 3'd3;
    @(posedge clk); #1 rd_addr = 3'd5;
    check("t5_stream_rvalid", rd_rvalid, 1);
    rst = 0;
    #1;
    check("t5_async_rvalid", rd_rvalid, 0);
    check("t5_async_rdata", rd_rdata, 0);
    idle();
    @(posedge clk); #1 rst = 1;
    wait_init();

    // T6: random traffic against the reference model
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      w0_valid = 1'($urandom_range(0, 1));
      w1_valid = 1'($urandom_range(0, 1));
      rd_valid = 1'($urandom_range(0, 1));
      w0_addr  = AW'($urandom_range(0, DEPTH - 1));
      w1_addr  = AW'($urandom_range(0, DEPTH - 1));
      rd_addr  = AW'($urandom_range(0, DEPTH - 1));
      w0_data  = $urandom;
      w1_data  = $urandom;
    end
    @(posedge clk); #1 idle();
    repeat (3) @(negedge clk);
    check("t6_w1_max_wait_ok", (w1_wait_max <= LIMIT) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
